// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-digit blanking gaps,
// leading-zero suppression and frame-synchronous double-buffered value updates.
module seg7_scan_driver #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic        eclk,
  input  logic        gsr,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dig_en,
  output logic        CA,
  output logic        CB,
  output logic        CC,
  output logic        CD,
  output logic        CE,
  output logic        CF,
  output logic        CG,
  output logic        ann0,
  output logic        ann1,
  output logic        ann2,
  output logic        ann3,
  output logic        frame
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    DRIVE = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  digit_q, digit_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] disp_q, disp_d;
  logic        pend_q, pend_d;
  logic        wrap_q, wrap_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        frame_q, frame_d;

  logic [3:0]  nib;
  logic [15:0] upper;
  logic        shown;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    case (h)
      4'h0: hex_glyph = 7'b0000001;
      4'h1: hex_glyph = 7'b1001111;
      4'h2: hex_glyph = 7'b0010010;
      4'h3: hex_glyph = 7'b0000110;
      4'h4: hex_glyph = 7'b1001100;
      4'h5: hex_glyph = 7'b0100100;
      4'h6: hex_glyph = 7'b0100000;
      4'h7: hex_glyph = 7'b0001111;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0000100;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b1100000;
      4'hC: hex_glyph = 7'b0110001;
      4'hD: hex_glyph = 7'b1000010;
      4'hE: hex_glyph = 7'b0110000;
      default: hex_glyph = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digit_d  = digit_q;
    wrap_d   = 1'b0;
    nib      = disp_q[{digit_q, 2'b00} +: 4];
    upper    = disp_q >> {digit_q, 2'b00};
    // Digit 0 always shows, even when the whole value is zero.
    shown    = (digit_q == 2'd0) || (LZ_SUPPRESS == 0) || (upper != 16'h0000);

    case (state_q)
      DRIVE: begin
        if (cnt_q == CW'(DIGIT_CYCLES - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = DRIVE;
          cnt_d   = '0;
          digit_d = digit_q + 2'd1;
          wrap_d  = (digit_q == 2'd3);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // Transfer uses the pre-edge shadow; a load on the wrap edge stays pending.
    disp_d   = (wrap_d && pend_q) ? shadow_q : disp_q;
    shadow_d = load ? value : shadow_q;
    pend_d   = pend_q;
    if (wrap_d) pend_d = 1'b0;
    if (load)   pend_d = 1'b1;

    an_d    = 4'hF;
    seg_d   = 7'h7F;
    if (state_q == DRIVE && dig_en[digit_q] && shown) begin
      an_d[digit_q] = 1'b0;
      seg_d         = hex_glyph(nib);
    end
    frame_d = wrap_q;
  end

  always_ff @(posedge eclk) begin
    if (!gsr) begin
      state_q  <= DRIVE;
      cnt_q    <= '0;
      digit_q  <= 2'd0;
      shadow_q <= 16'h0000;
      disp_q   <= 16'h0000;
      pend_q   <= 1'b0;
      wrap_q   <= 1'b0;
      seg_q    <= 7'h7F;
      an_q     <= 4'hF;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      wrap_q   <= wrap_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      frame_q  <= frame_d;
    end
  end

  assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
  assign {ann3, ann2, ann1, ann0}     = an_q;
  assign frame                        = frame_q;

endmodule
